ccip_rd_port_mux: RTL and testbench
===================================

Name: ccip_rd_port_mux

Overview:
- Shares one CCI-P c0 read-request channel among NUM_PORTS independent AFU read clients.
- Arbitrates requests round-robin and tags each mdata with the winning port index.
- Routes c0 read responses back to the issuing port and tracks per-port outstanding reads.
- Sits between AFU compute engines (e.g. ternary matmul operand fetchers) and the MPF-converted c0 Tx/Rx wires inside the user AFU.

Parameters:
- NUM_PORTS, 4: number of client read ports; must be ≥2.
- ADDR_W, 42: cache-line address width.
- DATA_W, 512: read response data width.
- MDATA_W, 16: full CCI-P mdata width.
- PORT_ID_W, $clog2(NUM_PORTS): mdata MSBs used as the routing tag (derived; do not override).
- MAX_OUTSTANDING, 64: per-port in-flight read limit; power of 2, ≥2.

Ports:
- pClk  in  1  primary CCI-P clock.
- reset_n  in  1  synchronous, active-low reset.
- cl_req_valid  in  NUM_PORTS  per-port request valid.
- cl_req_addr  in  NUM_PORTS*ADDR_W  per-port line address.
- cl_req_mdata  in  NUM_PORTS*(MDATA_W-PORT_ID_W)  per-port client tag.
- cl_req_ready  out  NUM_PORTS  request accepted this cycle (one-hot or zero).
- cl_rsp_valid  out  NUM_PORTS  one-hot response valid.
- cl_rsp_data  out  DATA_W  response data, shared by all ports.
- cl_rsp_mdata  out  MDATA_W-PORT_ID_W  client tag with port ID stripped.
- c0_req_valid  out  1  read request to FIU.
- c0_req_addr  out  ADDR_W  address of the issued request.
- c0_req_mdata  out  MDATA_W  {port_id, client tag}.
- c0_alm_full  in  1  c0TxAlmFull from the FIU.
- c0_rsp_valid  in  1  read response valid (rspValid and read-response type).
- c0_rsp_data  in  DATA_W  response data.
- c0_rsp_mdata  in  MDATA_W  response mdata.
- err_underflow  out  NUM_PORTS  sticky: response received for a port with zero outstanding reads.

Behaviour:
- Reset values (reset_n low at a pClk edge):
  - c0_req_valid=0, cl_rsp_valid=0, cl_req_ready=0.
  - All outstanding counters cleared, err_underflow cleared, round-robin pointer set to port 0.
  - Data and address registers are don't-care.
- Eligibility: a port is eligible when cl_req_valid[i]=1 and outstanding[i] < MAX_OUTSTANDING.
- Grant:
  - The round-robin arbiter grants exactly one eligible port per cycle, only when c0_alm_full=0.
  - The search starts at the port after the last grant.
  - cl_req_ready is combinational, equal to the grant; handshake is valid & ready in the same cycle.
- Request path latency: 1 cycle. On the cycle after a grant, the registered c0_req_valid=1 with the granted address and c0_req_mdata={grant_idx, tag}. With no grant, c0_req_valid=0 the following cycle.
- c0_alm_full=1: no grants are made; the request already in the output register still issues. Almost-full slack covers this.
- Response path latency: 1 cycle, registered.
  - port = c0_rsp_mdata[MDATA_W-1 -: PORT_ID_W].
  - cl_rsp_valid[port]=1, cl_rsp_data = c0_rsp_data, cl_rsp_mdata = lower bits.
  - A port index ≥ NUM_PORTS drops the response; no valid is raised.
- Counters: width $clog2(MAX_OUTSTANDING)+1.
  - +1 on grant; −1 on response arrival, counted at input capture.
  - Grant and response on the same port in the same cycle leave the counter unchanged.
  - A response with outstanding=0 keeps the counter at 0 and sets err_underflow[port] until reset. This case covers responses arriving after a reset mid-operation; such responses are still delivered.
- Back-pressure: clients have no response ready and must always accept responses.

Optional Feature:
- Macro: CCIP_RD_MUX_STATS_EN.
- When defined, adds outputs:
  - stat_grants, NUM_PORTS*32: per-port granted requests.
  - stat_stall_cycles, 32: cycles with any eligible request blocked by c0_alm_full.
- Counters wrap modulo 2^32 and clear on reset.
- When undefined, these ports and registers are absent.

Decomposition:
- Package ccip_rd_mux_pkg holds:
  - port-ID width function;
  - typedef t_port_id;
  - typedef t_outst_cnt;
  - constant RSP_LATENCY=1.
- Sub-module rr_arbiter (parameter N) holds:
  - inputs: request vector, enable;
  - output: one-hot grant;
  - pointer updated only on a grant.

Test Plan:
- Ports 0–3 valid every cycle, c0_alm_full=0 → grants 0,1,2,3,0,… one per cycle; c0_req_mdata[15:14] follows the same order, one cycle late.
- Response with mdata=16'h8005 (NUM_PORTS=4) → cl_rsp_valid=4'b0100 the next cycle, cl_rsp_mdata=14'h0005, outstanding[2] decremented.
- Port 1 issues 64 reads with no responses → cl_req_ready[1] stays 0 while other ports are still granted; after one response, port 1 is granted again.
- Assert c0_alm_full for 10 cycles with all ports valid → no grants, c0_req_valid=0 after one cycle; with STATS_EN, stat_stall_cycles=10.
- Grant on port 3 and response for port 3 in the same cycle → outstanding[3] unchanged.
- Pulse reset_n low with 5 reads in flight, then return 5 responses → all responses delivered, err_underflow set for each responding port, counters remain 0.

Source files
------------

// File: rtl/ccip_rd_mux_pkg.sv
// Shared types and helpers for the CCI-P c0 read-port multiplexer.
package ccip_rd_mux_pkg;

    localparam int RSP_LATENCY = 1;

    localparam int DEF_NUM_PORTS       = 4;
    localparam int DEF_MAX_OUTSTANDING = 64;

    // Width of the routing tag carried in the mdata MSBs; at least one bit.
    function automatic int port_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [$clog2(DEF_NUM_PORTS)-1:0]     t_port_id;
    typedef logic [$clog2(DEF_MAX_OUTSTANDING):0] t_outst_cnt;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after the last granted port.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;
    int            idx;

    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= N) idx = idx - N;
                if (!found && req[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                    ptr_d    = (idx == N - 1) ? '0 : IW'(idx + 1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/ccip_rd_port_mux.sv
// Shares one CCI-P c0 read channel among NUM_PORTS clients, routing responses by mdata tag.
// Optional statistics counters are enabled with `define CCIP_RD_MUX_STATS_EN.
module ccip_rd_port_mux
    import ccip_rd_mux_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int ADDR_W          = 42,
    parameter int DATA_W          = 512,
    parameter int MDATA_W         = 16,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic                                            pClk,
    input  logic                                            reset_n,
    input  logic [NUM_PORTS-1:0]                            cl_req_valid,
    input  logic [NUM_PORTS*ADDR_W-1:0]                     cl_req_addr,
    input  logic [NUM_PORTS*(MDATA_W-port_id_w(NUM_PORTS))-1:0] cl_req_mdata,
    output logic [NUM_PORTS-1:0]                            cl_req_ready,
    output logic [NUM_PORTS-1:0]                            cl_rsp_valid,
    output logic [DATA_W-1:0]                               cl_rsp_data,
    output logic [MDATA_W-port_id_w(NUM_PORTS)-1:0]         cl_rsp_mdata,
    output logic                                            c0_req_valid,
    output logic [ADDR_W-1:0]                               c0_req_addr,
    output logic [MDATA_W-1:0]                              c0_req_mdata,
    input  logic                                            c0_alm_full,
    input  logic                                            c0_rsp_valid,
    input  logic [DATA_W-1:0]                               c0_rsp_data,
    input  logic [MDATA_W-1:0]                              c0_rsp_mdata,
    output logic [NUM_PORTS-1:0]                            err_underflow
`ifdef CCIP_RD_MUX_STATS_EN
    ,
    output logic [NUM_PORTS*32-1:0]                         stat_grants,
    output logic [31:0]                                     stat_stall_cycles
`endif
);

    localparam int PORT_ID_W = port_id_w(NUM_PORTS);
    localparam int TAG_W     = MDATA_W - PORT_ID_W;
    localparam int CNT_W     = $clog2(MAX_OUTSTANDING) + 1;

    logic [CNT_W-1:0]     outst_q [NUM_PORTS];
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] grant;
    logic [PORT_ID_W-1:0] gnt_idx;
    logic [PORT_ID_W-1:0] rsp_port;
    logic                 rsp_hit;
    logic [NUM_PORTS-1:0] rsp_onehot;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = cl_req_valid[i] && (outst_q[i] < CNT_W'(MAX_OUTSTANDING));
        end
    end

    // Reset blocks grants so no handshake can complete while state is being cleared.
    rr_arbiter #(
        .N(NUM_PORTS)
    ) u_arb (
        .clk  (pClk),
        .rst_n(reset_n),
        .req  (eligible),
        .en   (reset_n && !c0_alm_full),
        .gnt  (grant)
    );

    assign cl_req_ready = grant;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) gnt_idx = PORT_ID_W'(i);
        end
    end

    always_ff @(posedge pClk) begin
        if (!reset_n) c0_req_valid <= 1'b0;
        else          c0_req_valid <= |grant;
        c0_req_addr  <= cl_req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
        c0_req_mdata <= {gnt_idx, cl_req_mdata[int'(gnt_idx)*TAG_W +: TAG_W]};
    end

    assign rsp_port   = c0_rsp_mdata[MDATA_W-1 -: PORT_ID_W];
    assign rsp_hit    = c0_rsp_valid && (int'(rsp_port) < NUM_PORTS);
    assign rsp_onehot = rsp_hit ? (NUM_PORTS'(1) << rsp_port) : '0;

    always_ff @(posedge pClk) begin
        if (!reset_n) cl_rsp_valid <= '0;
        else          cl_rsp_valid <= rsp_onehot;
        cl_rsp_data  <= c0_rsp_data;
        cl_rsp_mdata <= c0_rsp_mdata[TAG_W-1:0];
    end

    // Late responses after a reset hit a zero counter: flag them, keep the counter at zero.
    always_ff @(posedge pClk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PORTS; i++) outst_q[i] <= '0;
            err_underflow <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (rsp_onehot[i] && (outst_q[i] == '0)) err_underflow[i] <= 1'b1;
                if (grant[i] && !rsp_onehot[i]) begin
                    outst_q[i] <= outst_q[i] + CNT_W'(1);
                end else if (!grant[i] && rsp_onehot[i] && (outst_q[i] != '0)) begin
                    outst_q[i] <= outst_q[i] - CNT_W'(1);
                end
            end
        end
    end

`ifdef CCIP_RD_MUX_STATS_EN
    always_ff @(posedge pClk) begin
        if (!reset_n) begin
            stat_grants       <= '0;
            stat_stall_cycles <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (grant[i]) stat_grants[i*32 +: 32] <= stat_grants[i*32 +: 32] + 32'd1;
            end
            if (c0_alm_full && (|eligible)) stat_stall_cycles <= stat_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ccip_rd_port_mux.sv
// Scoreboard bench for ccip_rd_port_mux: directed stimulus pushes expectations, a monitor pops.
module tb_ccip_rd_port_mux;

    localparam int NP = 4;
    localparam int AW = 42;
    localparam int DW = 512;
    localparam int MW = 16;
    localparam int TW = 14;

    logic              pClk = 1'b0;
    logic              reset_n;
    logic [NP-1:0]     cl_req_valid;
    logic [NP*AW-1:0]  cl_req_addr;
    logic [NP*TW-1:0]  cl_req_mdata;
    logic [NP-1:0]     cl_req_ready;
    logic [NP-1:0]     cl_rsp_valid;
    logic [DW-1:0]     cl_rsp_data;
    logic [TW-1:0]     cl_rsp_mdata;
    logic              c0_req_valid;
    logic [AW-1:0]     c0_req_addr;
    logic [MW-1:0]     c0_req_mdata;
    logic              c0_alm_full;
    logic              c0_rsp_valid;
    logic [DW-1:0]     c0_rsp_data;
    logic [MW-1:0]     c0_rsp_mdata;
    logic [NP-1:0]     err_underflow;
`ifdef CCIP_RD_MUX_STATS_EN
    logic [NP*32-1:0]  stat_grants;
    logic [31:0]       stat_stall_cycles;
`endif

    ccip_rd_port_mux dut (
        .pClk         (pClk),
        .reset_n      (reset_n),
        .cl_req_valid (cl_req_valid),
        .cl_req_addr  (cl_req_addr),
        .cl_req_mdata (cl_req_mdata),
        .cl_req_ready (cl_req_ready),
        .cl_rsp_valid (cl_rsp_valid),
        .cl_rsp_data  (cl_rsp_data),
        .cl_rsp_mdata (cl_rsp_mdata),
        .c0_req_valid (c0_req_valid),
        .c0_req_addr  (c0_req_addr),
        .c0_req_mdata (c0_req_mdata),
        .c0_alm_full  (c0_alm_full),
        .c0_rsp_valid (c0_rsp_valid),
        .c0_rsp_data  (c0_rsp_data),
        .c0_rsp_mdata (c0_rsp_mdata),
        .err_underflow(err_underflow)
`ifdef CCIP_RD_MUX_STATS_EN
        ,
        .stat_grants      (stat_grants),
        .stat_stall_cycles(stat_stall_cycles)
`endif
    );

    always #5 pClk = ~pClk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [MW-1:0] mdata;
    } req_t;

    typedef struct {
        logic [NP-1:0] v;
        logic [DW-1:0] d;
        logic [TW-1:0] m;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int model [NP];
    logic [NP-1:0] err_m;
    logic prev_g, prev_r, mon_en;

    function automatic logic [AW-1:0] addr_of(input int p);
        return 42'h300000100 + AW'(p * 16);
    endfunction

    function automatic logic [TW-1:0] tag_of(input int p);
        return 14'h1000 + TW'(p);
    endfunction

    function automatic logic [DW-1:0] pat(input int k);
        return {16{32'hA5A50000 | 32'(k)}};
    endfunction

    task automatic check(input string name, input logic [63:0] exp, input logic [63:0] act);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge pClk) begin
        if (mon_en) begin
            if (c0_req_valid === 1'b1) begin
                vectors++;
                if (req_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL req_unexpected: got addr %0h expected none", c0_req_addr);
                end else begin
                    req_t e;
                    e = req_q.pop_front();
                    vectors++;
                    if (c0_req_addr !== e.addr || c0_req_mdata !== e.mdata) begin
                        miscompares++;
                        $display("FAIL req_content: got %0h/%0h expected %0h/%0h",
                                 c0_req_addr, c0_req_mdata, e.addr, e.mdata);
                    end
                end
            end
            if (cl_rsp_valid !== '0) begin
                vectors++;
                if (rsp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rsp_unexpected: got valid %b expected none", cl_rsp_valid);
                end else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    vectors++;
                    if (cl_rsp_valid !== e.v || cl_rsp_data !== e.d || cl_rsp_mdata !== e.m) begin
                        miscompares++;
                        $display("FAIL rsp_content: got %b/%0h/%0h expected %b/%0h/%0h",
                                 cl_rsp_valid, cl_rsp_data[31:0], cl_rsp_mdata,
                                 e.v, e.d[31:0], e.m);
                    end
                end
            end
        end
    end

    // One clock of stimulus; inputs change just after the rising edge.
    task automatic cycle(input logic [NP-1:0] v, input logic [NP-1:0] exp_rdy,
                         input logic rv, input logic [MW-1:0] rm, input logic [DW-1:0] rd);
        int  gi, rp;
        bit  same;
        cl_req_valid = v;
        c0_rsp_valid = rv;
        c0_rsp_mdata = rm;
        c0_rsp_data  = rd;
        @(negedge pClk);
        check("ready", 64'(exp_rdy), 64'(cl_req_ready));
        check("req_valid", 64'(prev_g), 64'(c0_req_valid));
        check("rsp_valid", 64'(prev_r), 64'(|cl_rsp_valid));
        gi = 0;
        for (int i = 0; i < NP; i++) if (exp_rdy[i]) gi = i;
        rp = int'(rm[MW-1 -: 2]);
        if (exp_rdy != '0) req_q.push_back('{addr: addr_of(gi), mdata: {2'(gi), tag_of(gi)}});
        if (rv) rsp_q.push_back('{v: NP'(1) << rp, d: rd, m: rm[TW-1:0]});
        same = rv && (exp_rdy != '0) && (gi == rp);
        if (exp_rdy != '0 && !same) model[gi]++;
        if (rv && !same) begin
            if (model[rp] == 0) err_m[rp] = 1'b1;
            else model[rp]--;
        end
        if (same && model[rp] == 0) err_m[rp] = 1'b1;
        prev_g = (exp_rdy != '0);
        prev_r = rv;
        @(posedge pClk);
        #1;
    endtask

    task automatic idle();
        cycle('0, '0, 1'b0, '0, '0);
    endtask

    task automatic check_counters(input string name);
        for (int i = 0; i < NP; i++) check(name, 64'(model[i]), 64'(dut.outst_q[i]));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NP-1:0] seq3 [6];
        mon_en       = 1'b0;
        prev_g       = 1'b0;
        prev_r       = 1'b0;
        err_m        = '0;
        for (int i = 0; i < NP; i++) model[i] = 0;
        reset_n      = 1'b0;
        cl_req_valid = '0;
        c0_alm_full  = 1'b0;
        c0_rsp_valid = 1'b0;
        c0_rsp_mdata = '0;
        c0_rsp_data  = '0;
        for (int i = 0; i < NP; i++) begin
            cl_req_addr[i*AW +: AW]  = addr_of(i);
            cl_req_mdata[i*TW +: TW] = tag_of(i);
        end

        // Reset: outputs idle, and no grants even with every port requesting.
        @(posedge pClk);
        #1;
        cl_req_valid = '1;
        @(negedge pClk);
        check("rst_ready", 64'h0, 64'(cl_req_ready));
        check("rst_req_valid", 64'h0, 64'(c0_req_valid));
        check("rst_rsp_valid", 64'h0, 64'(cl_rsp_valid));
        check("rst_err", 64'h0, 64'(err_underflow));
        @(posedge pClk);
        #1;
        reset_n      = 1'b1;
        cl_req_valid = '0;
        mon_en       = 1'b1;
        check_counters("rst_outst");

        // Round robin with all ports requesting: 0,1,2,3,0,1,2,3.
        for (int k = 0; k < 8; k++) cycle('1, NP'(1) << (k % 4), 1'b0, '0, '0);
        idle();
        check_counters("rr_outst");

        // Response tagged for port 2.
        cycle('0, '0, 1'b1, 16'h8005, pat(1));
        idle();
        check("rsp_outst2", 64'd1, 64'(dut.outst_q[2]));

        // Fill port 1 to the in-flight limit: 2 already outstanding, 62 more.
        for (int k = 0; k < 62; k++) cycle(4'b0010, 4'b0010, 1'b0, '0, '0);
        check("full_outst1", 64'd64, 64'(dut.outst_q[1]));
        cycle(4'b0010, 4'b0000, 1'b0, '0, '0);
        seq3[0] = 4'b0100; seq3[1] = 4'b1000; seq3[2] = 4'b0001;
        seq3[3] = 4'b0100; seq3[4] = 4'b1000; seq3[5] = 4'b0001;
        for (int k = 0; k < 6; k++) cycle('1, seq3[k], 1'b0, '0, '0);
        cycle('0, '0, 1'b1, {2'b01, 14'h00AA}, pat(2));
        cycle(4'b0010, 4'b0010, 1'b0, '0, '0);
        idle();
        check_counters("full_outst");

        // Almost-full holds off every grant.
        c0_alm_full = 1'b1;
        for (int k = 0; k < 10; k++) cycle('1, '0, 1'b0, '0, '0);
        c0_alm_full = 1'b0;
        idle();
`ifdef CCIP_RD_MUX_STATS_EN
        check("stall_cycles", 64'd10, 64'(stat_stall_cycles));
`endif

        // Simultaneous grant and response on port 3.
        check("pre_same_outst3", 64'(model[3]), 64'(dut.outst_q[3]));
        cycle(4'b1000, 4'b1000, 1'b1, {2'b11, 14'h0033}, pat(3));
        idle();
        check_counters("same_outst");
        check("pre_rst_err", 64'h0, 64'(err_underflow));

        // Reset with reads in flight, then late responses.
        reset_n = 1'b0;
        @(negedge pClk);
        check("mid_rst_ready", 64'h0, 64'(cl_req_ready));
        @(posedge pClk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < NP; i++) model[i] = 0;
        err_m  = '0;
        prev_g = 1'b0;
        prev_r = 1'b0;
        check("post_rst_err", 64'h0, 64'(err_underflow));
        check_counters("post_rst_outst");
        cycle('0, '0, 1'b1, {2'b00, 14'h0100}, pat(10));
        cycle('0, '0, 1'b1, {2'b01, 14'h0101}, pat(11));
        cycle('0, '0, 1'b1, {2'b10, 14'h0102}, pat(12));
        cycle('0, '0, 1'b1, {2'b11, 14'h0103}, pat(13));
        cycle('0, '0, 1'b1, {2'b00, 14'h0104}, pat(14));
        idle();
        idle();
        check("late_err", 64'(err_m), 64'(err_underflow));
        check("late_err_all", 64'hF, 64'(err_underflow));
        check_counters("late_outst");

        check("req_q_drained", 64'h0, 64'(req_q.size()));
        check("rsp_q_drained", 64'h0, 64'(rsp_q.size()));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
